// File: rtl/bfifo_reg_fwft.sv
// bfifo_reg_fwft
// Single-clock FIFO with first-word-fall-through output. A RAM core (registered
// read) feeds a one-word FWFT stage: the head word is presented on rdata whenever
// nempty=1 and ren pops it. The counts and full/almost flags describe the core
// only; the FWFT word is not counted, so total capacity is DEPTH+1 words.
//
// Ports
//   clka        clock
//   rstb        synchronous active-high reset
//   wen, wdata  write request and data (accepted when nfull=1)
//   nfull       core not full
//   nafull      cnt_free > AFULL_TH
//   woverflow   sticky: write attempted while full
//   cnt_used    words held in the core (0..DEPTH)
//   cnt_free    DEPTH - cnt_used
//   ren         pop the head word
//   rdata       head word, valid while nempty=1
//   nempty      rdata holds a valid head word
//   naempty     cnt_used > AEMPTY_TH
//   roverflow   sticky: ren asserted while nempty=0
//   dbg_sig     {zeros, woverflow, roverflow, nafull, nempty}

module bfifo_reg_fwft #(
    parameter string RAM_STYLE = "distributed",
    parameter int    DWID      = 18,
    parameter int    AWID      = 6,
    parameter int    AFULL_TH  = 4,
    parameter int    AEMPTY_TH = 4,
    parameter int    DBG_WID   = 32
) (
    input  logic               clka,
    input  logic               rstb,
    input  logic               wen,
    input  logic [DWID-1:0]    wdata,
    output logic               nfull,
    output logic               nafull,
    output logic               woverflow,
    output logic [AWID:0]      cnt_used,
    output logic [AWID:0]      cnt_free,
    input  logic               ren,
    output logic [DWID-1:0]    rdata,
    output logic               nempty,
    output logic               naempty,
    output logic               roverflow,
    output logic [DBG_WID-1:0] dbg_sig
);

    localparam int DEPTH = 1 << AWID;
    localparam logic [AWID:0] DEPTH_C     = DEPTH[AWID:0];
    localparam logic [AWID:0] AFULL_C     = AFULL_TH[AWID:0];
    localparam logic [AWID:0] AEMPTY_C    = AEMPTY_TH[AWID:0];
    localparam logic [AWID:0] ONE_C       = {{AWID{1'b0}}, 1'b1};
    localparam logic [AWID-1:0] PTR_ONE_C = {{(AWID-1){1'b0}}, 1'b1};

    logic [AWID-1:0] wptr;
    logic [AWID-1:0] rptr;
    logic [DWID-1:0] ram_rd;
    logic            wr_acc;
    logic            core_ren;

    // Flags come from the registered count only, so a write into a full core is
    // rejected even when a pop happens on the same edge.
    assign nfull    = (cnt_used != DEPTH_C);
    assign cnt_free = DEPTH_C - cnt_used;
    assign nafull   = (cnt_free > AFULL_C);
    assign naempty  = (cnt_used > AEMPTY_C);

    assign wr_acc   = wen & nfull;
    // Refill the FWFT stage whenever it is empty or being popped this cycle.
    assign core_ren = (cnt_used != '0) & (~nempty | ren);

    always_comb begin
        dbg_sig      = '0;
        dbg_sig[3:0] = {woverflow, roverflow, nafull, nempty};
    end

    // Storage: the read is asynchronous here and registered into rdata below,
    // giving the one-cycle registered read of the core. A read and a write never
    // target the same address on one edge: a read needs cnt_used!=0, so rptr and
    // wptr can only coincide when the core is full, and then writes are blocked.
    generate
        if (RAM_STYLE == "block") begin : g_mem_block
            (* ram_style = "block" *) logic [DWID-1:0] mem [DEPTH];
            always_ff @(posedge clka) begin
                if (wr_acc && !rstb) mem[wptr] <= wdata;
            end
            assign ram_rd = mem[rptr];
        end else if (RAM_STYLE == "distributed") begin : g_mem_dist
            (* ram_style = "distributed" *) logic [DWID-1:0] mem [DEPTH];
            always_ff @(posedge clka) begin
                if (wr_acc && !rstb) mem[wptr] <= wdata;
            end
            assign ram_rd = mem[rptr];
        end else begin : g_mem_auto
            logic [DWID-1:0] mem [DEPTH];
            always_ff @(posedge clka) begin
                if (wr_acc && !rstb) mem[wptr] <= wdata;
            end
            assign ram_rd = mem[rptr];
        end
    endgenerate

    always_ff @(posedge clka) begin
        if (rstb) begin
            wptr      <= '0;
            rptr      <= '0;
            cnt_used  <= '0;
            rdata     <= '0;
            nempty    <= 1'b0;
            woverflow <= 1'b0;
            roverflow <= 1'b0;
        end else begin
            if (wr_acc) wptr <= wptr + PTR_ONE_C;
            if (wen && !nfull) woverflow <= 1'b1;

            if (core_ren) begin
                rdata  <= ram_rd;
                rptr   <= rptr + PTR_ONE_C;
                nempty <= 1'b1;
            end else if (ren && nempty) begin
                nempty <= 1'b0;
            end
            if (ren && !nempty) roverflow <= 1'b1;

            case ({wr_acc, core_ren})
                2'b10:   cnt_used <= cnt_used + ONE_C;
                2'b01:   cnt_used <= cnt_used - ONE_C;
                default: cnt_used <= cnt_used;
            endcase
        end
    end

endmodule

// File: tb/tb_bfifo_reg_fwft.sv
module tb_bfifo_reg_fwft;

    localparam int DWID    = 18;
    localparam int AWID    = 6;
    localparam int DBG_WID = 32;

    logic               clka = 1'b0;
    logic               rstb;
    logic               wen;
    logic [DWID-1:0]    wdata;
    logic               nfull;
    logic               nafull;
    logic               woverflow;
    logic [AWID:0]      cnt_used;
    logic [AWID:0]      cnt_free;
    logic               ren;
    logic [DWID-1:0]    rdata;
    logic               nempty;
    logic               naempty;
    logic               roverflow;
    logic [DBG_WID-1:0] dbg_sig;

    int checks   = 0;
    int failures = 0;

    logic [DWID-1:0] q[$];
    int              exp_cnt;

    always #5 clka = ~clka;

    bfifo_reg_fwft #(
        .RAM_STYLE("distributed"),
        .DWID(DWID),
        .AWID(AWID),
        .AFULL_TH(4),
        .AEMPTY_TH(4),
        .DBG_WID(DBG_WID)
    ) dut (
        .clka(clka),
        .rstb(rstb),
        .wen(wen),
        .wdata(wdata),
        .nfull(nfull),
        .nafull(nafull),
        .woverflow(woverflow),
        .cnt_used(cnt_used),
        .cnt_free(cnt_free),
        .ren(ren),
        .rdata(rdata),
        .nempty(nempty),
        .naempty(naempty),
        .roverflow(roverflow),
        .dbg_sig(dbg_sig)
    );

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_nfull"},     64'(nfull),     64'd1);
        chk({tag, "_nafull"},    64'(nafull),    64'd1);
        chk({tag, "_nempty"},    64'(nempty),    64'd0);
        chk({tag, "_naempty"},   64'(naempty),   64'd0);
        chk({tag, "_cnt_used"},  64'(cnt_used),  64'd0);
        chk({tag, "_cnt_free"},  64'(cnt_free),  64'd64);
        chk({tag, "_woverflow"}, 64'(woverflow), 64'd0);
        chk({tag, "_roverflow"}, 64'(roverflow), 64'd0);
        chk({tag, "_rdata"},     64'(rdata),     64'd0);
        chk({tag, "_dbg"},       64'(dbg_sig),   64'h2);
    endtask

    initial begin
        rstb  = 1'b1;
        wen   = 1'b0;
        ren   = 1'b0;
        wdata = '0;

        // ---------------- reset ----------------
        tick();
        tick();
        chk_reset_state("rst");
        rstb = 1'b0;

        // ---------------- three words, FWFT latency ----------------
        wen = 1'b1; wdata = 18'h1;
        tick();
        chk("w1_nempty", 64'(nempty), 64'd0);
        chk("w1_cnt",    64'(cnt_used), 64'd1);
        wdata = 18'h2;
        tick();
        chk("w2_nempty", 64'(nempty), 64'd1);
        chk("w2_rdata",  64'(rdata), 64'h1);
        chk("w2_cnt",    64'(cnt_used), 64'd1);
        wdata = 18'h3;
        tick();
        chk("w3_cnt",    64'(cnt_used), 64'd2);
        chk("w3_rdata",  64'(rdata), 64'h1);
        wen = 1'b0;
        ren = 1'b1;
        tick();
        chk("pop1_rdata", 64'(rdata), 64'h2);
        tick();
        chk("pop2_rdata", 64'(rdata), 64'h3);
        chk("pop2_nempty", 64'(nempty), 64'd1);
        tick();
        chk("pop3_nempty", 64'(nempty), 64'd0);
        chk("pop3_rdata_hold", 64'(rdata), 64'h3);
        chk("pop3_roverflow", 64'(roverflow), 64'd0);
        ren = 1'b0;

        // ---------------- fill 65 words, overflow, drain ----------------
        q.delete();
        wen = 1'b1;
        for (int k = 1; k <= 65; k++) begin
            wdata = 18'(32'h100 + k);
            q.push_back(wdata);
            tick();
            exp_cnt = (k == 1) ? 1 : k - 1;
            chk($sformatf("fill%0d_cnt", k), 64'(cnt_used), 64'(exp_cnt));
            chk($sformatf("fill%0d_nafull", k), 64'(nafull), 64'((64 - exp_cnt) > 4));
        end
        chk("full_nfull",   64'(nfull),    64'd0);
        chk("full_free",    64'(cnt_free), 64'd0);
        chk("full_naempty", 64'(naempty),  64'd1);
        chk("full_wovf0",   64'(woverflow), 64'd0);
        wdata = 18'h0DEAD;
        tick();
        chk("ovf_wovf",  64'(woverflow), 64'd1);
        chk("ovf_cnt",   64'(cnt_used),  64'd64);
        chk("ovf_dbg3",  64'(dbg_sig[3]), 64'd1);
        wen = 1'b0;
        for (int i = 0; i < 65; i++) begin
            chk($sformatf("drain%0d_nempty", i), 64'(nempty), 64'd1);
            chk($sformatf("drain%0d_rdata", i), 64'(rdata), 64'(q.pop_front()));
            ren = 1'b1;
            tick();
            ren = 1'b0;
        end
        chk("drain_end_nempty", 64'(nempty), 64'd0);
        chk("drain_end_cnt",    64'(cnt_used), 64'd0);
        chk("drain_end_rovf",   64'(roverflow), 64'd0);

        // ---------------- read underflow, sticky ----------------
        ren = 1'b1;
        tick();
        ren = 1'b0;
        chk("rovf_set",  64'(roverflow), 64'd1);
        chk("rovf_dbg2", 64'(dbg_sig[2]), 64'd1);
        tick();
        tick();
        chk("rovf_sticky", 64'(roverflow), 64'd1);
        chk("both_ovf_dbg", 64'(dbg_sig), 64'hE);

        // ---------------- clear, then streaming ----------------
        rstb = 1'b1;
        tick();
        tick();
        rstb = 1'b0;
        chk_reset_state("rst2");
        q.delete();
        wen = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wdata = 18'($urandom_range(0, 32'h3FFFF));
            q.push_back(wdata);
            tick();
        end
        chk("pre_nempty", 64'(nempty), 64'd1);
        chk("pre_cnt",    64'(cnt_used), 64'd1);
        ren = 1'b1;
        for (int i = 0; i < 200; i++) begin
            wdata = 18'($urandom_range(0, 32'h3FFFF));
            q.push_back(wdata);
            void'(q.pop_front());
            tick();
            chk($sformatf("strm%0d_rdata", i), 64'(rdata), 64'(q[0]));
            chk($sformatf("strm%0d_cnt", i), 64'(cnt_used), 64'd1);
        end
        wen = 1'b0;
        void'(q.pop_front());
        tick();
        chk("strm_tail_rdata",  64'(rdata), 64'(q[0]));
        chk("strm_tail_nempty", 64'(nempty), 64'd1);
        tick();
        ren = 1'b0;
        chk("strm_end_nempty", 64'(nempty), 64'd0);
        chk("strm_end_cnt",    64'(cnt_used), 64'd0);
        chk("strm_rovf",       64'(roverflow), 64'd0);
        chk("strm_wovf",       64'(woverflow), 64'd0);

        // ---------------- reset while half full ----------------
        wen = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wdata = 18'(32'h200 + k);
            tick();
        end
        wen = 1'b0;
        chk("half_cnt",    64'(cnt_used), 64'd9);
        chk("half_nempty", 64'(nempty), 64'd1);
        rstb = 1'b1;
        tick();
        rstb = 1'b0;
        chk_reset_state("rst3");
        wen = 1'b1; wdata = 18'h2A;
        tick();
        wen = 1'b0;
        tick();
        chk("post_rst_nempty", 64'(nempty), 64'd1);
        chk("post_rst_rdata",  64'(rdata), 64'h2A);
        chk("post_rst_cnt",    64'(cnt_used), 64'd0);
        ren = 1'b1;
        tick();
        ren = 1'b0;
        chk("post_rst_pop", 64'(nempty), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
